// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - handshake, ROM, regfile, memory and ALU control bundle for ctrl_sequencer
interface ctrl_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Ack;
  logic             Busy;
  logic [PC_W-1:0]  InstAddr;
  logic [8:0]       InstIn;
  logic [3:0]       OP;
  logic [2:0]       Im;
  logic [2:0]       RdAddrA;
  logic [2:0]       RdAddrB;
  logic [2:0]       WrAddr;
  logic             WrEn;
  logic             WrSel;
  logic             MemRdEn;
  logic             MemWrEn;
  logic             Branch;
  logic [2:0]       LutIdx;
  logic [PC_W-1:0]  LutTarget;
  logic [CNT_W-1:0] InstCount;

  modport master (
    input  Start, InstIn, Branch, LutTarget,
    output Ack, Busy, InstAddr, OP, Im, RdAddrA, RdAddrB, WrAddr,
           WrEn, WrSel, MemRdEn, MemWrEn, LutIdx, InstCount
  );

  modport slave (
    output Start, InstIn, Branch, LutTarget,
    input  Ack, Busy, InstAddr, OP, Im, RdAddrA, RdAddrB, WrAddr,
           WrEn, WrSel, MemRdEn, MemWrEn, LutIdx, InstCount
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle fetch/decode/control sequencer driving the ALU and memories
module ctrl_sequencer #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  ctrl_sequencer_if.master bus
);

  localparam logic [3:0] OP_BNZL = 4'd10;
  localparam logic [3:0] OP_BNZR = 4'd11;
  localparam logic [3:0] OP_LDR  = 4'd12;
  localparam logic [3:0] OP_STR  = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;
  localparam logic [8:0] IR_HALT = 9'h1E0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_LOAD,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [PC_W-1:0]  pc, pc_next, pc_inc;
  logic [8:0]       ir, ir_next;
  logic [CNT_W-1:0] inst_count, count_next;
  logic             retire;

  // Fields of the instruction arriving from ROM this cycle, and of the held IR
  logic [3:0] in_op, ir_op;
  logic [2:0] in_rd, in_rs, ir_rd, ir_rs;

  logic [3:0] op;
  logic [2:0] im, rd_addr_a, rd_addr_b, wr_addr, lut_idx;
  logic       wr_en, wr_sel, mem_rd_en, mem_wr_en;

  assign in_op  = bus.InstIn[8:5];
  assign in_rd  = {1'b0, bus.InstIn[4:3]};
  assign in_rs  = bus.InstIn[2:0];
  assign ir_op  = ir[8:5];
  assign ir_rd  = {1'b0, ir[4:3]};
  assign ir_rs  = ir[2:0];
  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  // State, PC, IR and retired-instruction counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= START_ADDR;
      ir         <= IR_HALT;
      inst_count <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ir         <= ir_next;
      inst_count <= count_next;
    end
  end

  // Next-state, PC update and decoded control outputs
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    count_next = inst_count;
    retire     = 1'b0;
    op         = 4'hF;
    im         = 3'd0;
    rd_addr_a  = 3'd0;
    rd_addr_b  = 3'd0;
    wr_addr    = 3'd0;
    lut_idx    = 3'd0;
    wr_en      = 1'b0;
    wr_sel     = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          pc_next    = START_ADDR;
          count_next = '0;
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        state_next = S_EXEC;
      end

      S_EXEC: begin
        // ROM data is only valid now, so decode straight from InstIn and keep a copy for LOAD
        ir_next    = bus.InstIn;
        op         = in_op;
        im         = in_rs;
        rd_addr_a  = in_rd;
        rd_addr_b  = in_rs;
        wr_addr    = in_rd;
        pc_next    = pc_inc;
        retire     = 1'b1;
        state_next = S_FETCH;
        case (in_op)
          OP_BNZL, OP_BNZR: begin
            // The ALU tests R[rd], so it goes out on port B; Im selects the LUT entry
            rd_addr_b = in_rd;
            lut_idx   = in_rs;
            if (bus.Branch) begin
              pc_next = bus.LutTarget;
            end
          end
          OP_LDR: begin
            mem_rd_en  = 1'b1;
            pc_next    = pc;
            retire     = 1'b0;
            state_next = S_LOAD;
          end
          OP_STR: begin
            mem_wr_en = 1'b1;
          end
          OP_NOP: begin
          end
          OP_HALT: begin
            pc_next    = pc;
            state_next = S_DONE;
          end
          default: begin
            wr_en = 1'b1;
          end
        endcase
      end

      S_LOAD: begin
        // Memory data returns this cycle; write it back to rd
        op         = ir_op;
        im         = ir_rs;
        rd_addr_a  = ir_rd;
        rd_addr_b  = ir_rs;
        wr_addr    = ir_rd;
        wr_en      = 1'b1;
        wr_sel     = 1'b1;
        pc_next    = pc_inc;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (retire && (inst_count != {CNT_W{1'b1}})) begin
      count_next = inst_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.Ack       = (state == S_DONE);
  assign bus.Busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_LOAD);
  assign bus.InstAddr  = pc;
  assign bus.OP        = op;
  assign bus.Im        = im;
  assign bus.RdAddrA   = rd_addr_a;
  assign bus.RdAddrB   = rd_addr_b;
  assign bus.WrAddr    = wr_addr;
  assign bus.WrEn      = wr_en;
  assign bus.WrSel     = wr_sel;
  assign bus.MemRdEn   = mem_rd_en;
  assign bus.MemWrEn   = mem_wr_en;
  assign bus.LutIdx    = lut_idx;
  assign bus.InstCount = inst_count;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;

  localparam int PC_W  = 8;
  localparam int CNT_W = 4;
  localparam logic [7:0] START_PC = 8'h00;
  localparam logic [8:0] HALT_W   = 9'h1E0;
  localparam logic [8:0] NOP_W    = 9'h1C0;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ctrl_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  ctrl_sequencer #(.PC_W(PC_W), .START_ADDR(START_PC), .CNT_W(CNT_W)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [8:0] rom   [256];
  logic       br_at [256];
  logic [7:0] lut   [8];

  // Synchronous instruction ROM, combinational LUT, branch flag chosen per address
  always @(posedge Clk) bus.InstIn <= rom[bus.InstAddr];
  assign bus.LutTarget = lut[bus.LutIdx];
  assign bus.Branch    = br_at[bus.InstAddr];

  typedef struct packed {
    logic       ack;
    logic       busy;
    logic [7:0] addr;
    logic [3:0] op;
    logic [2:0] im;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic       wren;
    logic       wrsel;
    logic       mrd;
    logic       mwr;
    logic [2:0] lidx;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    logic [8:0] instr;
    logic       br;
    logic [7:0] tgt;
    logic [3:0] op;
    logic [2:0] im, ra, rb, wa;
    logic       wren, mrd, mwr;
    logic [2:0] lidx;
    logic [7:0] next_pc;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t exp_q[$];

  function automatic obs_t base(logic ack, logic busy, logic [7:0] addr, logic [3:0] cnt);
    obs_t o;
    o      = '0;
    o.ack  = ack;
    o.busy = busy;
    o.addr = addr;
    o.op   = 4'hF;
    o.cnt  = cnt;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.ack   = bus.Ack;
    s.busy  = bus.Busy;
    s.addr  = bus.InstAddr;
    s.op    = bus.OP;
    s.im    = bus.Im;
    s.ra    = bus.RdAddrA;
    s.rb    = bus.RdAddrB;
    s.wa    = bus.WrAddr;
    s.wren  = bus.WrEn;
    s.wrsel = bus.WrSel;
    s.mrd   = bus.MemRdEn;
    s.mwr   = bus.MemWrEn;
    s.lidx  = bus.LutIdx;
    s.cnt   = bus.InstCount;
    return s;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ack=%b busy=%b addr=%h op=%h im=%0d ra=%0d rb=%0d wa=%0d we=%b ws=%b mr=%b mw=%b li=%0d cnt=%0d",
                     o.ack, o.busy, o.addr, o.op, o.im, o.ra, o.rb, o.wa,
                     o.wren, o.wrsel, o.mrd, o.mwr, o.lidx, o.cnt);
  endfunction

  task automatic chk_obs(input string name, input obs_t req);
    obs_t act;
    act = sample();
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual {%s} required {%s}", name, fmt(act), fmt(req));
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int a = 0; a < 256; a++) begin
      rom[a]   = w;
      br_at[a] = 1'b0;
    end
    for (int j = 0; j < 8; j++) lut[j] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset     = 1'b1;
    bus.Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Leaves the bench observing the first FETCH cycle
  task automatic start_pulse();
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  function automatic logic [3:0] sat_inc(logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // Instruction-level reference: walks the program and lists the per-cycle view of each instruction
  task automatic build_trace(input int max_instr, output logic halted);
    logic [7:0] pc;
    logic [3:0] cnt;
    logic [8:0] w;
    obs_t       e;
    pc     = START_PC;
    cnt    = 4'd0;
    halted = 1'b0;
    exp_q.delete();
    for (int i = 0; i < max_instr && !halted; i++) begin
      w = rom[pc];
      exp_q.push_back(base(1'b0, 1'b1, pc, cnt));
      e    = base(1'b0, 1'b1, pc, cnt);
      e.op = w[8:5];
      e.im = w[2:0];
      e.ra = {1'b0, w[4:3]};
      e.rb = w[2:0];
      e.wa = {1'b0, w[4:3]};
      case (w[8:5])
        4'd10, 4'd11: begin
          e.rb   = e.ra;
          e.lidx = w[2:0];
          exp_q.push_back(e);
          pc = br_at[pc] ? lut[w[2:0]] : pc + 8'd1;
        end
        4'd12: begin
          e.mrd = 1'b1;
          exp_q.push_back(e);
          e.mrd   = 1'b0;
          e.wren  = 1'b1;
          e.wrsel = 1'b1;
          exp_q.push_back(e);
          pc = pc + 8'd1;
        end
        4'd13: begin
          e.mwr = 1'b1;
          exp_q.push_back(e);
          pc = pc + 8'd1;
        end
        4'd14: begin
          exp_q.push_back(e);
          pc = pc + 8'd1;
        end
        4'd15: begin
          exp_q.push_back(e);
          halted = 1'b1;
        end
        default: begin
          e.wren = 1'b1;
          exp_q.push_back(e);
          pc = pc + 8'd1;
        end
      endcase
      cnt = sat_inc(cnt);
    end
    if (halted) begin
      exp_q.push_back(base(1'b1, 1'b0, pc, cnt));
      exp_q.push_back(base(1'b1, 1'b0, pc, cnt));
    end
  endtask

  vec_t vt[10];
  obs_t e;
  int   n;
  logic halted;

  initial begin
    Reset     = 1'b1;
    bus.Start = 1'b0;

    //           instr          br    tgt    op     im    ra    rb    wa    we    mr    mw    li    next
    vt[0] = '{9'b0001_01_011, 1'b0, 8'h00, 4'h1, 3'd3, 3'd1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01};
    vt[1] = '{9'b1011_10_101, 1'b1, 8'h20, 4'hB, 3'd5, 3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 3'd5, 8'h20};
    vt[2] = '{9'b1011_10_101, 1'b0, 8'h20, 4'hB, 3'd5, 3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 3'd5, 8'h01};
    vt[3] = '{9'b1010_01_010, 1'b1, 8'h07, 4'hA, 3'd2, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h07};
    vt[4] = '{9'b1101_00_111, 1'b0, 8'h00, 4'hD, 3'd7, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01};
    vt[5] = '{9'b1110_11_110, 1'b1, 8'h40, 4'hE, 3'd6, 3'd3, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01};
    vt[6] = '{9'b0000_11_001, 1'b1, 8'h40, 4'h0, 3'd1, 3'd3, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01};
    vt[7] = '{9'b1001_10_100, 1'b1, 8'h40, 4'h9, 3'd4, 3'd2, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01};
    vt[8] = '{9'b1111_01_001, 1'b1, 8'h40, 4'hF, 3'd1, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
    vt[9] = '{9'b1100_11_100, 1'b0, 8'h00, 4'hC, 3'd4, 3'd3, 3'd4, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};

    // Single-instruction decode table: EXEC-cycle outputs and the following InstAddr
    for (int i = 0; i < 10; i++) begin
      fill_rom(HALT_W);
      rom[0]   = vt[i].instr;
      br_at[0] = vt[i].br;
      for (int j = 0; j < 8; j++) lut[j] = vt[i].tgt;
      do_reset();
      start_pulse();
      @(negedge Clk);
      e      = base(1'b0, 1'b1, START_PC, 4'd0);
      e.op   = vt[i].op;
      e.im   = vt[i].im;
      e.ra   = vt[i].ra;
      e.rb   = vt[i].rb;
      e.wa   = vt[i].wa;
      e.wren = vt[i].wren;
      e.mrd  = vt[i].mrd;
      e.mwr  = vt[i].mwr;
      e.lidx = vt[i].lidx;
      chk_obs($sformatf("vec%0d_exec", i), e);
      @(negedge Clk);
      chk($sformatf("vec%0d_next_addr", i), int'(bus.InstAddr), int'(vt[i].next_pc));
    end

    // ADDI then HALT: reset state, Ack latency, count, Ack hold, restart from DONE
    fill_rom(HALT_W);
    rom[0] = 9'b0001_01_011;
    do_reset();
    chk_obs("reset_state", base(1'b0, 1'b0, START_PC, 4'd0));
    start_pulse();
    n = 1;
    while (!bus.Ack && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("t1_cycles_to_ack", n, 5);
    chk("t1_count", int'(bus.InstCount), 2);
    @(negedge Clk);
    chk("t1_ack_held", int'(bus.Ack), 1);
    start_pulse();
    chk_obs("t1_restart", base(1'b0, 1'b1, START_PC, 4'd0));

    // LDR r3,[r4]: three cycles, write-back only in the LOAD cycle
    fill_rom(HALT_W);
    rom[0] = 9'b1100_11_100;
    do_reset();
    start_pulse();
    @(negedge Clk);
    e     = base(1'b0, 1'b1, 8'h00, 4'd0);
    e.op  = 4'hC;
    e.im  = 3'd4;
    e.ra  = 3'd3;
    e.rb  = 3'd4;
    e.wa  = 3'd3;
    e.mrd = 1'b1;
    chk_obs("ldr_exec", e);
    @(negedge Clk);
    e.mrd   = 1'b0;
    e.wren  = 1'b1;
    e.wrsel = 1'b1;
    chk_obs("ldr_load", e);
    @(negedge Clk);
    chk_obs("ldr_next_fetch", base(1'b0, 1'b1, 8'h01, 4'd1));

    // Start during FETCH is ignored; Reset during LOAD returns to IDLE cleanly
    fill_rom(HALT_W);
    rom[0] = NOP_W;
    rom[1] = 9'b1100_11_100;
    do_reset();
    start_pulse();
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    e    = base(1'b0, 1'b1, 8'h00, 4'd0);
    e.op = 4'hE;
    chk_obs("t5_start_in_fetch_ignored", e);
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    e      = base(1'b0, 1'b1, 8'h01, 4'd1);
    e.op   = 4'hC;
    e.im   = 3'd4;
    e.ra   = 3'd3;
    e.rb   = 3'd4;
    e.wa   = 3'd3;
    e.wren = 1'b1;
    e.wrsel = 1'b1;
    chk_obs("t5_in_load", e);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk_obs("t5_after_reset", base(1'b0, 1'b0, START_PC, 4'd0));
    @(negedge Clk);
    chk_obs("t5_idle_hold", base(1'b0, 1'b0, START_PC, 4'd0));

    // Branch to 0xFF, NOP there, PC wraps to 0x00
    fill_rom(HALT_W);
    rom[0]   = 9'b1010_00_000;
    rom[255] = NOP_W;
    br_at[0] = 1'b1;
    for (int j = 0; j < 8; j++) lut[j] = 8'hFF;
    do_reset();
    start_pulse();
    @(negedge Clk);
    @(negedge Clk);
    chk("wrap_fetch_ff", int'(bus.InstAddr), 8'hFF);
    @(negedge Clk);
    @(negedge Clk);
    chk_obs("wrap_fetch_00", base(1'b0, 1'b1, 8'h00, 4'd2));

    // Retired-instruction counter saturates
    fill_rom(NOP_W);
    rom[20] = HALT_W;
    do_reset();
    start_pulse();
    n = 1;
    while (!bus.Ack && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("sat_cycles_to_ack", n, 43);
    chk("sat_count", int'(bus.InstCount), 15);

    // Random programs against the instruction-level model, with Start noise while busy
    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < 256; a++) begin
        rom[a]   = 9'($urandom);
        br_at[a] = 1'($urandom);
      end
      for (int j = 0; j < 8; j++) lut[j] = 8'($urandom);
      do_reset();
      build_trace(40, halted);
      start_pulse();
      foreach (exp_q[k]) begin
        chk_obs($sformatf("rand%0d_cyc%0d", r, k), exp_q[k]);
        bus.Start = exp_q[k].busy ? 1'($urandom) : 1'b0;
        @(negedge Clk);
      end
      bus.Start = 1'b0;
      if (halted) begin
        start_pulse();
        chk_obs($sformatf("rand%0d_restart", r), base(1'b0, 1'b1, START_PC, 4'd0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
